// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED mic volume bar path.
package oled_pkg;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;
  localparam int MIC_MID     = 2048;
  localparam int VOL_MAX     = 15;
  localparam int VOL_W       = 5;
  localparam int MAG_W       = 11;
  localparam int LVL_SHIFT   = 7;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PEND
  } lvl_state_e;

  function automatic logic [MAG_W-1:0] mag_max(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vol_peak_hold.sv
// Peak-hold with decay on per-window levels; the held level is published
// to the display only on a frame start so a frame never shows two values.
module vol_peak_hold
  import oled_pkg::*;
#(
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY_STEP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_stb,
  input  logic [VOL_W-1:0] raw_level,
  input  logic             frame_start,
  output logic [VOL_W-1:0] volume,
  output logic             volume_valid
);

  localparam int HC_W = $clog2(HOLD_WINDOWS + 1);

  lvl_state_e       state_reg;
  logic [VOL_W-1:0] held_reg;
  logic [HC_W-1:0]  hold_cnt_reg;
  logic [VOL_W-1:0] volume_reg;
  logic             volume_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      held_reg         <= '0;
      hold_cnt_reg     <= '0;
      volume_reg       <= '0;
      volume_valid_reg <= 1'b0;
    end else begin
      volume_valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (commit_stb) state_reg <= EVAL;
        end
        EVAL: begin
          if (raw_level >= held_reg) begin
            held_reg     <= raw_level;
            hold_cnt_reg <= HC_W'(HOLD_WINDOWS);
          end else if (hold_cnt_reg != '0) begin
            hold_cnt_reg <= hold_cnt_reg - 1'b1;
          end else if (held_reg > VOL_W'(DECAY_STEP)) begin
            held_reg <= held_reg - VOL_W'(DECAY_STEP);
          end else begin
            held_reg <= '0;
          end
          state_reg <= PEND;
        end
        PEND: begin
          // A coincident commit publishes the already-evaluated level first.
          if (frame_start) begin
            volume_reg       <= held_reg;
            volume_valid_reg <= (held_reg != volume_reg);
          end
          if (commit_stb)       state_reg <= EVAL;
          else if (frame_start) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign volume       = volume_reg;
  assign volume_valid = volume_valid_reg;

endmodule

// File: rtl/mic_volume_ctrl.sv
// Mic sample -> windowed peak level -> frame-aligned volume, plus the
// pixel_index to (x, y) mapping for the bar renderer.
module mic_volume_ctrl #(
  parameter int SAMPLE_W     = 12,
  parameter int MIC_MID      = 2048,
  parameter int WINDOW       = 4096,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY_STEP   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                sample_valid,
  input  logic [12:0]         pixel_index,
  output logic [6:0]          x,
  output logic [5:0]          y,
  output logic [4:0]          volume,
  output logic                volume_valid
);

  import oled_pkg::*;

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [SAMPLE_W-1:0] MID     = SAMPLE_W'(MIC_MID);
  localparam logic [SAMPLE_W-1:0] MAG_TOP = SAMPLE_W'((1 << MAG_W) - 1);

  logic [SAMPLE_W-1:0] abs_diff;
  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    acc_next;
  logic [MAG_W-1:0]    acc_max_reg;
  logic [MAG_W-1:0]    peak_reg;
  logic [CNT_W-1:0]    win_cnt_reg;
  logic                commit_stb_reg;
  logic [VOL_W-1:0]    raw_level;

  // Offset-binary to magnitude; only a full-negative sample needs clipping.
  assign abs_diff = (mic_sample >= MID) ? (mic_sample - MID) : (MID - mic_sample);
  assign mag      = (abs_diff > MAG_TOP) ? MAG_TOP[MAG_W-1:0] : abs_diff[MAG_W-1:0];
  assign acc_next = mag_max(acc_max_reg, mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max_reg    <= '0;
      peak_reg       <= '0;
      win_cnt_reg    <= '0;
      commit_stb_reg <= 1'b0;
    end else begin
      commit_stb_reg <= 1'b0;
      if (sample_valid) begin
        if (win_cnt_reg == CNT_W'(WINDOW - 1)) begin
          peak_reg       <= acc_next;
          acc_max_reg    <= '0;
          win_cnt_reg    <= '0;
          commit_stb_reg <= 1'b1;
        end else begin
          acc_max_reg <= acc_next;
          win_cnt_reg <= win_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign raw_level = VOL_W'(peak_reg >> LVL_SHIFT);

  vol_peak_hold #(
    .HOLD_WINDOWS(HOLD_WINDOWS),
    .DECAY_STEP  (DECAY_STEP)
  ) u_peak_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .commit_stb  (commit_stb_reg),
    .raw_level   (raw_level),
    .frame_start (pixel_index == 13'd0),
    .volume      (volume),
    .volume_valid(volume_valid)
  );

  logic [12:0] rem;
  logic [5:0]  row;
  logic        in_range;
  logic [6:0]  x_reg;
  logic [5:0]  y_reg;

  // Restoring division by 96: one compare-subtract per quotient bit.
  always_comb begin
    rem = pixel_index;
    row = '0;
    for (int i = 5; i >= 0; i--) begin
      if (rem >= 13'(OLED_W << i)) begin
        rem    = rem - 13'(OLED_W << i);
        row[i] = 1'b1;
      end
    end
  end

  assign in_range = (pixel_index < 13'(OLED_PIXELS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= in_range ? rem[6:0] : 7'd0;
      y_reg <= in_range ? (6'(OLED_H - 1) - row) : 6'd0;
    end
  end

  assign x = x_reg;
  assign y = y_reg;

endmodule

// File: tb/tb_mic_volume_ctrl.sv
// Directed bench for mic_volume_ctrl with a short window and hold.
module tb_mic_volume_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mic_sample = '0;
  logic        sample_valid = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [4:0]  volume;
  logic        volume_valid;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;
  int exp_vol;

  always #5 clk = ~clk;

  mic_volume_ctrl #(
    .SAMPLE_W    (12),
    .MIC_MID     (2048),
    .WINDOW      (4),
    .HOLD_WINDOWS(2),
    .DECAY_STEP  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mic_sample  (mic_sample),
    .sample_valid(sample_valid),
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y),
    .volume      (volume),
    .volume_valid(volume_valid)
  );

  always @(negedge clk) if (rst_n && volume_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] s);
    mic_sample   = s;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic window(input logic [11:0] last);
    send(12'd2048);
    send(12'd2048);
    send(12'd2048);
    send(last);
  endtask

  task automatic frame();
    pixel_index = 13'd0;
    @(posedge clk);
    #1;
    pixel_index = 13'd100;
  endtask

  task automatic pix(input logic [12:0] idx, input int ex, input int ey);
    pixel_index = idx;
    @(posedge clk);
    #1;
    chk("pix_x", 32'(x), ex);
    chk("pix_y", 32'(y), ey);
    pixel_index = 13'd100;
  endtask

  initial begin
    // Reset with activity on the inputs
    sample_valid = 1'b1;
    mic_sample   = 12'd0;
    pixel_index  = 13'd0;
    idle(6);
    chk("rst_volume", 32'(volume), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_valid", 32'(volume_valid), 0);
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    pixel_index  = 13'd100;
    idle(2);
    chk("post_rst_x", 32'(x), 4);
    chk("post_rst_y", 32'(y), 62);
    chk("post_rst_volume", 32'(volume), 0);
    chk("post_rst_pulses", 32'(pulses), 0);

    // Pixel mapping
    pix(13'd0, 0, 63);
    pix(13'd95, 95, 63);
    pix(13'd96, 0, 62);
    pix(13'd3000, 24, 32);
    pix(13'd6143, 95, 0);
    pix(13'd6200, 0, 0);

    // Level 7, held back until frame start
    p0 = pulses;
    send(12'd2048);
    send(12'd2048);
    send(12'd3000);
    send(12'd2048);
    idle(3);
    chk("lvl7_before_frame", 32'(volume), 0);
    frame();
    chk("lvl7_volume", 32'(volume), 7);
    chk("lvl7_valid", 32'(volume_valid), 1);
    idle(1);
    chk("lvl7_valid_drop", 32'(volume_valid), 0);
    chk("lvl7_pulses", 32'(pulses - p0), 1);

    // Level 10 then silence: hold two windows, then decay by one
    p0 = pulses;
    window(12'd3348);
    idle(3);
    frame();
    chk("lvl10_volume", 32'(volume), 10);
    idle(1);
    chk("lvl10_pulses", 32'(pulses - p0), 1);
    for (int i = 0; i < 14; i++) begin
      p0 = pulses;
      window(12'd2048);
      idle(3);
      frame();
      exp_vol = (i < 2) ? 10 : (((10 - (i - 1)) > 0) ? (10 - (i - 1)) : 0);
      chk("decay_volume", 32'(volume), 32'(exp_vol));
      idle(1);
      chk("decay_pulses", 32'(pulses - p0), (i >= 2 && i <= 11) ? 1 : 0);
    end

    // Latest wins: levels 5 then 12 with no frame start between
    p0 = pulses;
    window(12'd2748);
    idle(3);
    window(12'd3648);
    idle(3);
    chk("latest_before_frame", 32'(volume), 0);
    chk("latest_no_pulse", 32'(pulses - p0), 0);
    frame();
    chk("latest_volume", 32'(volume), 12);
    idle(1);
    chk("latest_pulses", 32'(pulses - p0), 1);

    // Frame start coincident with commit: level 14 loads, sample 0 gives 15 later
    window(12'd3898);
    idle(3);
    p0 = pulses;
    window(12'd0);
    frame();
    chk("coinc_old_volume", 32'(volume), 14);
    idle(4);
    chk("coinc_still_old", 32'(volume), 14);
    chk("coinc_pulses", 32'(pulses - p0), 1);
    frame();
    chk("coinc_new_volume", 32'(volume), 15);
    idle(1);
    chk("coinc_new_pulses", 32'(pulses - p0), 2);

    // Full-scale positive sample, unchanged value gives no pulse
    p0 = pulses;
    window(12'd4095);
    idle(3);
    frame();
    chk("max_pos_volume", 32'(volume), 15);
    idle(1);
    chk("max_pos_no_pulse", 32'(pulses - p0), 0);

    // Mid-window asynchronous reset
    send(12'd0);
    send(12'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_volume", 32'(volume), 0);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_y", 32'(y), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulses;
    window(12'd2448);
    idle(3);
    chk("midrst_before_frame", 32'(volume), 0);
    frame();
    chk("midrst_volume_after", 32'(volume), 3);
    idle(1);
    chk("midrst_pulses", 32'(pulses - p0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_volume_ctrl.md
Name: mic_volume_ctrl

Overview:
Sequences the mic volume bar display. It converts raw mic samples into a windowed peak level and applies peak-hold with decay. It commits the resulting 5-bit volume to the bar renderer only at OLED frame start, so no frame tears. It also maps the OLED driver's linear pixel_index to the renderer's x/y coordinates (y origin at bottom).

Parameters:
SAMPLE_W, 12, mic sample width (unsigned, offset-binary)
MIC_MID, 2048, DC midpoint subtracted from each sample
WINDOW, 4096, valid samples per peak window (>=2)
HOLD_WINDOWS, 8, windows a new peak is held before decay starts
DECAY_STEP, 1, level decrement per window once hold expires

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mic_sample  in  12  raw mic sample
sample_valid  in  1  one-cycle strobe qualifying mic_sample
pixel_index  in  13  OLED driver pixel index, 0..6143, row-major, top row first
x  out  7  column for renderer, 0..95
y  out  6  row for renderer, 0 = bottom, 63 = top
volume  out  5  displayed level, 0..15
volume_valid  out  1  one-cycle pulse when volume changes value

Behaviour:
Reset:
- Clock and reset are one clock `clk`; reset `rst_n` is asynchronous, active-low.
- x=0, y=0, volume=0, volume_valid=0.
- Window counter=0, window max=0, held level=0, hold counter=0, pending=0.

Magnitude (on sample_valid):
- mag = |mic_sample - MIC_MID|, saturated to 11 bits (sample 0 gives 2047).

Window accumulation (never stalls):
- On each valid sample: acc_max = max(acc_max, mag); win_cnt increments.
- On the WINDOW-th valid sample, in the same cycle:
  - peak = max(acc_max, mag) is captured into peak_reg.
  - acc_max clears to 0, win_cnt clears to 0.
  - commit_stb is raised for the next cycle.
  - A sample on the following cycle belongs to the new window.
- raw_level = peak_reg >> 7, giving 0..15.

Level FSM (vol_peak_hold): states IDLE, EVAL, PEND.
- IDLE → EVAL on commit_stb.
- EVAL, one cycle:
  - If raw_level >= held: held=raw_level, hold_cnt=HOLD_WINDOWS.
  - Else if hold_cnt>0: hold_cnt-1.
  - Else: held = max(0, held-DECAY_STEP).
  - Then go to PEND with pending=1.
- PEND → IDLE when frame start is seen (pixel_index==0 sampled this cycle):
  - volume <= held.
  - volume_valid=1 for one cycle, only if the new value differs from the old one.
  - pending=0.
- commit_stb while in PEND → EVAL. The newer level overwrites the pending one (latest wins); no window is ever lost from the hold logic.
- Frame start while IDLE or EVAL: no volume change.
- Frame start and commit_stb in the same cycle while in PEND: volume loads the old held value, then EVAL runs.

Pixel mapping (1-cycle registered latency):
- x = pixel_index mod 96.
- y = 63 - (pixel_index div 96).
- pixel_index >= 6144: x=0, y=0.
- Implemented by row/column compare-subtract, not a generic divider.

Mid-operation reset:
- Asserting rst_n low at any point returns all state to reset values immediately.
- The first window after reset release starts at win_cnt=0.

Decomposition:
Shared package oled_pkg:
- OLED_W=96, OLED_H=64, OLED_PIXELS=6144
- MIC_MID=2048, VOL_MAX=15, VOL_W=5
- Level FSM state enum {IDLE, EVAL, PEND}

One sub-module: vol_peak_hold (EVAL/PEND FSM, hold counter, decay, frame-aligned volume commit).
Magnitude/window logic and pixel mapping stay in the top level.

Test Plan:
- Reset: hold rst_n=0 with activity on inputs, release → volume=0, x=0, y=0, volume_valid never pulses.
- Pixel map: pixel_index=0 → x=0, y=63 next cycle; 95 → x=95, y=63; 96 → x=0, y=62; 6143 → x=95, y=0; 6200 → x=0, y=0.
- Level and frame alignment (WINDOW=4): samples 2048, 2048, 3000, 2048 → peak 952, level 7. volume stays 0 until pixel_index==0, then volume=7 with a single volume_valid pulse. Extremes: sample 0 → level 15; sample 4095 → level 15.
- Hold/decay (WINDOW=4, HOLD_WINDOWS=2, DECAY_STEP=1): one window at level 10, then silent windows with a frame start after each → volume 10, 10, 10, 9, 8 ... down to 0, then stays 0 with no further pulses.
- Latest wins: two windows complete (levels 5, then 12) with no frame start between → next frame start gives volume=12, one pulse. Frame start coincident with commit_stb in PEND → old value loads, new value appears at the following frame.
- Mid-operation reset: assert rst_n low mid-window (win_cnt=2) → state clears asynchronously. The next full WINDOW after release produces the level from post-reset samples only.
